// File: rtl/uart_rx_pkg.sv
// Shared UART receiver constants and FSM state encoding.
// Oversampling ratio and sample points are common with the transmitter.
package uart_rx_pkg;

  localparam int          OVERSAMPLE = 16;
  localparam logic [3:0]  MID_START  = 4'd7;
  localparam logic [3:0]  LAST_TICK  = 4'(OVERSAMPLE - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } rx_state_e;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Reset value is a parameter so idle-high lines do not glitch out of reset.
module uart_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers start/data/stop frames from rx using a 16x baud tick,
// delivers each word on d_out with a one-cycle rx_done strobe and flags bad stop bits.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] d_out,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy
);

  localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           tick_cnt_q, tick_cnt_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] d_out_q, d_out_d;
  logic                 err_q, err_d;
  logic                 armed_q, armed_d;
  logic                 rx_done_q, rx_done_d;
  logic                 frame_err_q, frame_err_d;
  logic                 busy_q, busy_d;
  logic                 rx_s;

  uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path through the case infers a latch.
    state_d     = state_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    d_out_d     = d_out_q;
    err_d       = err_q;
    armed_d     = armed_q;
    rx_done_d   = 1'b0;
    frame_err_d = frame_err_q;

    case (state_q)
      IDLE: begin
        if (rx_s) armed_d = 1'b1;
        if (armed_q && !rx_s) begin
          state_d    = START;
          tick_cnt_d = 4'd0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt_q == MID_START) begin
            if (rx_s) begin
              state_d = IDLE;
            end else begin
              state_d    = DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 4'd0;
              err_d      = 1'b0;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 4'd1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = 4'd0;
              state_d   = STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == LAST_TICK) begin
            if (!rx_s) err_d = 1'b1;
            if (bit_cnt_q == LAST_STOP) begin
              d_out_d     = shift_q;
              frame_err_d = err_q | ~rx_s;
              rx_done_d   = 1'b1;
              bit_cnt_d   = 4'd0;
              // A low final stop bit is a break: wait for the line to go high again.
              armed_d     = rx_s;
              state_d     = IDLE;
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        armed_d = 1'b0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      d_out_q     <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b1;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: state flops use non-blocking assignments so all update from the same pre-edge values.
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      d_out_q     <= d_out_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
      rx_done_q   <= rx_done_d;
      frame_err_q <= frame_err_d;
      busy_q      <= busy_d;
    end
  end

  assign d_out     = d_out_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frame scenarios plus random byte streams
// for one and two stop bits, scored against a frame-level model of expected words.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic       rx1 = 1'b1;
  logic       rx2 = 1'b1;
  logic [7:0] d1, d2;
  logic       done1, done2, fe1, fe2, busy1, busy2;

  int tick_div = 27;
  int tick_cnt = 0;
  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  // Each entry is {frame_err, data}.
  logic [8:0] got1[$], exp1[$], got2[$], exp2[$];
  logic [8:0] prev1, prev2;
  logic       prev_done1, prev_done2;

  uart_rx #(.DATA_BITS(8), .STOP_BITS(1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx1),
    .d_out(d1), .rx_done(done1), .frame_err(fe1), .busy(busy1)
  );

  uart_rx #(.DATA_BITS(8), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx2),
    .d_out(d2), .rx_done(done2), .frame_err(fe2), .busy(busy2)
  );

  always #10 clk = ~clk;

  always @(posedge clk) begin
    if (tick_cnt >= tick_div - 1) begin
      tick_cnt <= 0;
      tick     <= 1'b1;
    end else begin
      tick_cnt <= tick_cnt + 1;
      tick     <= 1'b0;
    end
  end

  // Collect delivered words; outputs may only move together with rx_done, which never repeats.
  always @(negedge clk) begin
    if (!reset) begin
      if (done1) got1.push_back({fe1, d1});
      if (done2) got2.push_back({fe2, d2});
      if ((done1 && prev_done1) || (done2 && prev_done2)) viol <= viol + 1;
      if ((!done1 && {fe1, d1} != prev1) || (!done2 && {fe2, d2} != prev2)) viol <= viol + 1;
    end
    prev1      <= {fe1, d1};
    prev2      <= {fe2, d2};
    prev_done1 <= done1;
    prev_done2 <= done2;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive(input int sel, input logic b, input int nclk);
    if (sel == 1) rx1 = b;
    else          rx2 = b;
    repeat (nclk) @(negedge clk);
  endtask

  // Serialise one frame and record what a correct receiver must deliver for it.
  task automatic send_frame(input int sel, input logic [7:0] data, input logic stop_val,
                            input int nstop);
    int bl;
    bl = 16 * tick_div;
    drive(sel, 1'b0, bl);
    for (int i = 0; i < 8; i++) drive(sel, data[i], bl);
    for (int i = 0; i < nstop; i++) drive(sel, stop_val, bl);
    if (sel == 1) exp1.push_back({~stop_val, data});
    else          exp2.push_back({~stop_val, data});
  endtask

  task automatic compare_q(input string tag, input int sel);
    logic [8:0] g[$], e[$];
    if (sel == 1) begin
      g = got1; e = exp1; got1.delete(); exp1.delete();
    end else begin
      g = got2; e = exp2; got2.delete(); exp2.delete();
    end
    check({tag, "_count"}, g.size(), e.size());
    for (int i = 0; i < g.size() && i < e.size(); i++) check(tag, g[i], e[i]);
  endtask

  initial begin
    logic [7:0] b;
    repeat (3) @(negedge clk);
    check("rst_dout", d1, 8'h00);
    check("rst_done", done1, 1'b0);
    check("rst_ferr", fe1, 1'b0);
    check("rst_busy", busy1, 1'b0);
    reset = 1'b0;
    repeat (40) @(negedge clk);

    // Plain frame at the real baud ratio.
    send_frame(1, 8'h55, 1'b1, 1);
    repeat (20) @(negedge clk);
    compare_q("frame55", 1);
    check("frame55_busy", busy1, 1'b0);

    // Short low glitch must be rejected at the start-bit centre.
    drive(1, 1'b0, 4 * tick_div);
    check("glitch_busy", busy1, 1'b1);
    drive(1, 1'b1, 32 * tick_div);
    compare_q("glitch", 1);
    check("glitch_dout", d1, 8'h55);
    check("glitch_idle", busy1, 1'b0);

    // Faster tick for the remaining directed scenarios.
    tick_div = 4;
    drive(1, 1'b1, 32 * tick_div);

    send_frame(1, 8'hA3, 1'b0, 1);
    drive(1, 1'b0, 3 * 10 * 16 * tick_div);
    compare_q("break", 1);
    drive(1, 1'b1, 16 * tick_div);
    send_frame(1, 8'h3C, 1'b1, 1);
    drive(1, 1'b1, 16 * tick_div);
    compare_q("after_break", 1);

    send_frame(1, 8'h00, 1'b1, 1);
    send_frame(1, 8'hFF, 1'b1, 1);
    send_frame(1, 8'h81, 1'b1, 1);
    drive(1, 1'b1, 16 * tick_div);
    compare_q("b2b", 1);

    // Reset in the middle of a data phase discards the partial frame.
    b = 8'h7E;
    drive(1, 1'b0, 16 * tick_div);
    for (int i = 0; i < 3; i++) drive(1, b[i], 16 * tick_div);
    check("mid_busy", busy1, 1'b1);
    reset = 1'b1;
    #1;
    check("mid_rst_dout", d1, 8'h00);
    check("mid_rst_busy", busy1, 1'b0);
    check("mid_rst_done", done1, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    drive(1, 1'b1, 32 * tick_div);
    send_frame(1, 8'h12, 1'b1, 1);
    drive(1, 1'b1, 16 * tick_div);
    compare_q("post_rst", 1);

    // Random streams with occasional zero-length idle gaps.
    tick_div = 2;
    drive(1, 1'b1, 32 * tick_div);
    for (int n = 0; n < 48; n++) begin
      send_frame(1, 8'($urandom), 1'b1, 1);
      if ($urandom_range(1, 0) == 1) drive(1, 1'b1, $urandom_range(16 * tick_div, 1));
    end
    drive(1, 1'b1, 16 * tick_div);
    compare_q("rand_stop1", 1);

    for (int n = 0; n < 48; n++) begin
      send_frame(2, 8'($urandom), 1'b1, 2);
      if ($urandom_range(1, 0) == 1) drive(2, 1'b1, $urandom_range(16 * tick_div, 1));
    end
    drive(2, 1'b1, 16 * tick_div);
    compare_q("rand_stop2", 2);

    check("done_dout_stable", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
